mips_mc_controller: RTL and testbench

Control FSM for the multicycle MIPS datapath that follows the single-cycle core in the same tree. It decodes the instruction register opcode/funct each instruction and sequences the shared unified memory, ALU, register file and PC over 3–5 cycles. It also stretches memory accesses under a `mem_ready` handshake. It sits inside the multicycle `mips` wrapper beside the datapath; `top` and the existing bench exercise it unchanged.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/mips_aludec.sv | 36 +++
 rtl/mips_mc_controller.sv | 162 ++++++++++++++++
 tb/tb_mips_mc_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller:
// opcodes, functs, ALU codes, mux selects and FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEXEC,
    S_ADDIWB,
    S_JUMP
  } state_t;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: aluop/funct to alucontrol, plus a
// funct legality flag used by the illegal check.
module mips_aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_ok
);

  logic [2:0] w_fn_alu;

  always_comb begin
    w_fn_alu = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      F_ADD:   w_fn_alu = ALU_ADD;
      F_SUB:   w_fn_alu = ALU_SUB;
      F_AND:   w_fn_alu = ALU_AND;
      F_OR:    w_fn_alu = ALU_OR;
      F_SLT:   w_fn_alu = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      AOP_SUB: alucontrol = ALU_SUB;
      AOP_FN:  alucontrol = w_fn_alu;
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences memory, ALU,
// register file and PC, stretching on mem_ready.
module mips_mc_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       instr_done,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic       w_funct_ok;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_is_mem;
  logic       w_is_r;

  mips_aludec u_aludec (
    .aluop      (w_aluop),
    .funct      (funct),
    .alucontrol (alucontrol),
    .funct_ok   (w_funct_ok)
  );

  assign w_is_mem = (op == OP_LW) | (op == OP_SW);
  assign w_is_r   = (op == OP_RTYPE) & w_funct_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_aluop    = AOP_ADD;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PC_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        alusrcb = SRCB_4;
        if (mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        unique case (1'b1)
          w_is_mem:        w_next = S_MEMADR;
          w_is_r:          w_next = S_EXECUTE;
          (op == OP_BEQ):  w_next = S_BRANCH;
          (op == OP_ADDI): w_next = S_ADDIEXEC;
          (op == OP_J):    w_next = S_JUMP;
          default: begin
            illegal = 1'b1;
            w_next  = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        // strobe held through the wait; memory commits on mem_ready
        iord       = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = AOP_FN;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        w_aluop    = AOP_SUB;
        pcsrc      = PC_ALUOUT;
        w_branch   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = PC_JUMP;
        w_pcwrite  = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // write enables are held off while reset is low
  assign pcen     = reset & (w_pcwrite | (w_branch & zero));
  assign irwrite  = reset & w_irwrite;
  assign memwrite = reset & w_memwrite;
  assign regwrite = reset & w_regwrite;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: directed
// per-cycle expected outputs, checked by a monitor.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, iord, memwrite, irwrite;
  logic       regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       instr_done, illegal;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  string       name_q[$];
  logic [16:0] w_act;

  mips_mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcen       (pcen),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  assign w_act = {pcen, iord, memwrite, irwrite, regdst,
                  memtoreg, regwrite, alusrca, alusrcb,
                  pcsrc, alucontrol, instr_done, illegal};

  function automatic logic [16:0] ex(
    input logic pe, io, mw, ir, rd, mtr, rw, sa,
    input logic [1:0] sb, ps,
    input logic [2:0] alu,
    input logic dn, il);
    return {pe, io, mw, ir, rd, mtr, rw, sa, sb, ps, alu, dn, il};
  endfunction

  function automatic logic [16:0] e_rst();
    return ex(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010,0,0);
  endfunction
  function automatic logic [16:0] e_fetch(input logic mr);
    return ex(mr,0,0,mr,0,0,0,0,2'b01,2'b00,3'b010,0,0);
  endfunction
  function automatic logic [16:0] e_decode(input logic il);
    return ex(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0,il);
  endfunction
  function automatic logic [16:0] e_memadr();
    return ex(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
  endfunction
  function automatic logic [16:0] e_memrd();
    return ex(0,1,0,0,0,0,0,0,2'b00,2'b00,3'b010,0,0);
  endfunction
  function automatic logic [16:0] e_memwb();
    return ex(0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010,1,0);
  endfunction
  function automatic logic [16:0] e_memwr(input logic mr);
    return ex(0,1,1,0,0,0,0,0,2'b00,2'b00,3'b010,mr,0);
  endfunction
  function automatic logic [16:0] e_exec(input logic [2:0] alu);
    return ex(0,0,0,0,0,0,0,1,2'b00,2'b00,alu,0,0);
  endfunction
  function automatic logic [16:0] e_aluwb();
    return ex(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b010,1,0);
  endfunction
  function automatic logic [16:0] e_branch(input logic z);
    return ex(z,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,1,0);
  endfunction
  function automatic logic [16:0] e_addiex();
    return ex(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0,0);
  endfunction
  function automatic logic [16:0] e_addiwb();
    return ex(0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010,1,0);
  endfunction
  function automatic logic [16:0] e_jump();
    return ex(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b010,1,0);
  endfunction

  task automatic step(input logic rs, input logic [5:0] o,
                      input logic [5:0] f, input logic z,
                      input logic mr, input logic [16:0] e,
                      input string n);
    @(posedge clk);
    #1;
    reset     = rs;
    op        = o;
    funct     = f;
    zero      = z;
    mem_ready = mr;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic chk(input logic ok, input string n,
                     input logic [16:0] a, input logic [16:0] e);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask

  initial begin : monitor
    logic [16:0] e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk(w_act === e, n, w_act, e);
      end
    end
  end

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000, J = 6'b000010;

  initial begin : stim
    reset = 1'b0; op = '0; funct = '0;
    zero = 1'b0; mem_ready = 1'b1;
    step(0, LW, 0, 0, 1, e_rst(), "reset_hold0");
    step(0, LW, 0, 0, 1, e_rst(), "reset_hold1");
    // lw, zero wait: 5 cycles
    step(1, LW, 0, 0, 1, e_fetch(1), "lw_fetch");
    step(1, LW, 0, 0, 1, e_decode(0), "lw_decode");
    step(1, LW, 0, 0, 1, e_memadr(), "lw_memadr");
    step(1, LW, 0, 0, 1, e_memrd(), "lw_memrd");
    step(1, LW, 0, 0, 1, e_memwb(), "lw_memwb");
    // R-type slt
    step(1, RT, 6'b101010, 0, 1, e_fetch(1), "slt_fetch");
    step(1, RT, 6'b101010, 0, 1, e_decode(0), "slt_decode");
    step(1, RT, 6'b101010, 0, 1, e_exec(3'b111), "slt_exec");
    step(1, RT, 6'b101010, 0, 1, e_aluwb(), "slt_aluwb");
    // R-type sub and or
    step(1, RT, 6'b100010, 0, 1, e_fetch(1), "sub_fetch");
    step(1, RT, 6'b100010, 0, 1, e_decode(0), "sub_decode");
    step(1, RT, 6'b100010, 0, 1, e_exec(3'b110), "sub_exec");
    step(1, RT, 6'b100010, 0, 1, e_aluwb(), "sub_aluwb");
    step(1, RT, 6'b100101, 0, 1, e_fetch(1), "or_fetch");
    step(1, RT, 6'b100101, 0, 1, e_decode(0), "or_decode");
    step(1, RT, 6'b100101, 0, 1, e_exec(3'b001), "or_exec");
    step(1, RT, 6'b100101, 0, 1, e_aluwb(), "or_aluwb");
    // beq taken, then not taken
    step(1, BEQ, 0, 1, 1, e_fetch(1), "beq1_fetch");
    step(1, BEQ, 0, 1, 1, e_decode(0), "beq1_decode");
    step(1, BEQ, 0, 1, 1, e_branch(1), "beq1_branch");
    step(1, BEQ, 0, 0, 1, e_fetch(1), "beq0_fetch");
    step(1, BEQ, 0, 0, 1, e_decode(0), "beq0_decode");
    step(1, BEQ, 0, 0, 1, e_branch(0), "beq0_branch");
    // sw with 3 wait cycles: 7 cycles
    step(1, SW, 0, 0, 1, e_fetch(1), "sw_fetch");
    step(1, SW, 0, 0, 1, e_decode(0), "sw_decode");
    step(1, SW, 0, 0, 1, e_memadr(), "sw_memadr");
    step(1, SW, 0, 0, 0, e_memwr(0), "sw_wait1");
    step(1, SW, 0, 0, 0, e_memwr(0), "sw_wait2");
    step(1, SW, 0, 0, 0, e_memwr(0), "sw_wait3");
    step(1, SW, 0, 0, 1, e_memwr(1), "sw_commit");
    // illegal opcode, then illegal funct
    step(1, 6'b111111, 0, 0, 1, e_fetch(1), "ilop_fetch");
    step(1, 6'b111111, 0, 0, 1, e_decode(1), "ilop_decode");
    step(1, RT, 6'b000000, 0, 1, e_fetch(1), "ilfn_fetch");
    step(1, RT, 6'b000000, 0, 1, e_decode(1), "ilfn_decode");
    // addi
    step(1, ADDI, 0, 0, 1, e_fetch(1), "addi_fetch");
    step(1, ADDI, 0, 0, 1, e_decode(0), "addi_decode");
    step(1, ADDI, 0, 0, 1, e_addiex(), "addi_exec");
    step(1, ADDI, 0, 0, 1, e_addiwb(), "addi_wb");
    // j with one fetch wait
    step(1, J, 0, 0, 0, e_fetch(0), "j_fetchwait");
    step(1, J, 0, 0, 1, e_fetch(1), "j_fetch");
    step(1, J, 0, 0, 1, e_decode(0), "j_decode");
    step(1, J, 0, 0, 1, e_jump(), "j_jump");
    // lw with one read wait
    step(1, LW, 0, 0, 1, e_fetch(1), "lw2_fetch");
    step(1, LW, 0, 0, 1, e_decode(0), "lw2_decode");
    step(1, LW, 0, 0, 1, e_memadr(), "lw2_memadr");
    step(1, LW, 0, 0, 0, e_memrd(), "lw2_rdwait");
    step(1, LW, 0, 0, 1, e_memrd(), "lw2_memrd");
    step(1, LW, 0, 0, 1, e_memwb(), "lw2_memwb");
    // reset asserted mid-MEMWR
    step(1, SW, 0, 0, 1, e_fetch(1), "swr_fetch");
    step(1, SW, 0, 0, 1, e_decode(0), "swr_decode");
    step(1, SW, 0, 0, 1, e_memadr(), "swr_memadr");
    step(1, SW, 0, 0, 0, e_memwr(0), "swr_wait");
    step(0, SW, 0, 0, 1, e_rst(), "swr_rst0");
    #1;
    chk(memwrite === 1'b0 && iord === 1'b0 &&
        alusrcb === 2'b01 && irwrite === 1'b0,
        "async_reset", w_act, e_rst());
    step(0, SW, 0, 0, 1, e_rst(), "swr_rst1");
    step(1, SW, 0, 0, 1, e_fetch(1), "post_release");
    step(1, SW, 0, 0, 1, e_decode(0), "post_decode");
    begin : drain
      int n = 0;
      while (exp_q.size() > 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: got %0d pending expected 0",
                 exp_q.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
